// File: rtl/prog_delay_line_if.sv
// Streaming bus for prog_delay_line: sample input, delay control and delayed output.
//   master : drives in_valid, in_data, delay_load, delay_in; observes the outputs
//   slave  : the delay line itself
//   in_valid/in_data   accepted sample, lane c at in_data[c*N +: N]
//   delay_load/delay_in single-cycle strobe applying a new delay in samples
//   out_valid/out_data  delayed sample, same lane packing
//   locked/cur_delay    line is emitting (RUN) / delay currently in effect
interface prog_delay_line_if #(
  parameter int N         = 16,
  parameter int CH        = 2,
  parameter int MAX_DELAY = 32
);
  localparam int DW = $clog2(MAX_DELAY);

  logic              in_valid;
  logic [CH*N-1:0]   in_data;
  logic              delay_load;
  logic [DW-1:0]     delay_in;
  logic              out_valid;
  logic [CH*N-1:0]   out_data;
  logic              locked;
  logic [DW-1:0]     cur_delay;

  modport master (
    output in_valid, in_data, delay_load, delay_in,
    input  out_valid, out_data, locked, cur_delay
  );

  modport slave (
    input  in_valid, in_data, delay_load, delay_in,
    output out_valid, out_data, locked, cur_delay
  );
endinterface

// File: rtl/prog_delay_line.sv
// Programmable multi-channel sample delay line.
// Delay is counted in accepted samples. Samples go into a circular buffer; the
// output of each accepted sample is the sample D positions earlier, registered
// one clock later. After a reset or a delay change the line stays in FILL until
// D samples have been written under the new delay, so stale or mixed-delay
// samples never reach the output.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  prog_delay_line_if.slave (in_valid, in_data, delay_load, delay_in,
//        out_valid, out_data, locked, cur_delay)
module prog_delay_line #(
  parameter int N          = 16,
  parameter int CH         = 2,
  parameter int MAX_DELAY  = 32,
  parameter int INIT_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  prog_delay_line_if.slave bus
);
  localparam int DW = $clog2(MAX_DELAY);
  localparam int CW = DW + 1;
  localparam int W  = CH * N;

  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DW-1:0] INIT_D     = DW'(INIT_DELAY);
  localparam state_t        INIT_STATE = (INIT_DELAY == 0) ? RUN : FILL;
  localparam logic [CW-1:0] FILL_MAX   = CW'(MAX_DELAY);

  logic [W-1:0]  mem_r [MAX_DELAY];
  state_t        state_r;
  state_t        state_nxt_s;
  logic [DW-1:0] wr_ptr_r;
  logic [DW-1:0] cur_delay_r;
  logic [DW-1:0] delay_nxt_s;
  logic [DW-1:0] rd_addr_s;
  logic [CW-1:0] fill_cnt_r;
  logic [CW-1:0] fill_base_s;
  logic [CW-1:0] fill_nxt_s;
  logic          run_base_s;
  logic          emit_s;
  logic          locked_r;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [W-1:0]  rd_data_s;

  // Next-state logic: a load takes effect before the coincident sample is judged.
  always_comb begin
    delay_nxt_s = cur_delay_r;
    fill_base_s = fill_cnt_r;
    run_base_s  = (state_r == RUN);
    emit_s      = 1'b0;
    state_nxt_s = state_r;
    fill_nxt_s  = fill_cnt_r;

    if (bus.delay_load) begin
      delay_nxt_s = bus.delay_in;
      fill_base_s = {CW{1'b0}};
      run_base_s  = (bus.delay_in == {DW{1'b0}});
    end else begin
      delay_nxt_s = cur_delay_r;
      fill_base_s = fill_cnt_r;
      run_base_s  = (state_r == RUN);
    end

    if (bus.in_valid) begin
      // The sample whose pre-increment count equals D is the first one whose
      // delayed partner was written under the current delay.
      emit_s      = run_base_s || (fill_base_s == {1'b0, delay_nxt_s});
      state_nxt_s = emit_s ? RUN : FILL;
      fill_nxt_s  = (fill_base_s == FILL_MAX) ? FILL_MAX
                                               : fill_base_s + {{DW{1'b0}}, 1'b1};
    end else begin
      emit_s      = 1'b0;
      state_nxt_s = run_base_s ? RUN : FILL;
      fill_nxt_s  = fill_base_s;
    end
  end

  // Read path: D=0 bypasses the buffer since that slot is being written now.
  always_comb begin
    rd_addr_s = wr_ptr_r - delay_nxt_s;
    if (delay_nxt_s == {DW{1'b0}}) begin
      rd_data_s = bus.in_data;
    end else begin
      rd_data_s = mem_r[rd_addr_s];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= INIT_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointer, fill count, delay setting and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {DW{1'b0}};
      fill_cnt_r  <= {CW{1'b0}};
      cur_delay_r <= INIT_D;
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      locked_r    <= (INIT_DELAY == 0) ? 1'b1 : 1'b0;
    end else begin
      cur_delay_r <= delay_nxt_s;
      fill_cnt_r  <= fill_nxt_s;
      out_valid_r <= emit_s;
      locked_r    <= (state_nxt_s == RUN);
      if (bus.in_valid) begin
        wr_ptr_r <= wr_ptr_r + {{(DW-1){1'b0}}, 1'b1};
      end
      if (emit_s) begin
        out_data_r <= rd_data_s;
      end
    end
  end

  // Sample buffer; left unreset because FILL gating hides stale entries.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.locked    = locked_r;
  assign bus.cur_delay = cur_delay_r;
endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line (N=16, CH=2, MAX_DELAY=32, INIT_DELAY=0).
// A history-queue model predicts every output each cycle; directed literal
// checks pin the key scenarios.
module tb_prog_delay_line;
  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  prog_delay_line_if #(.N(16), .CH(2), .MAX_DELAY(32)) bus ();

  prog_delay_line #(.N(16), .CH(2), .MAX_DELAY(32), .INIT_DELAY(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted sample since reset, the delay, and samples since load.
  logic [31:0] hist[$];
  int          m_delay  = 0;
  int          m_since  = 0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_data   = 32'h0;
  logic        m_locked = 1'b1;

  always @(posedge clk or posedge rst) begin : model
    int d;
    int s;
    logic v;
    logic [31:0] dat;
    if (rst) begin
      hist.delete();
      m_delay  <= 0;
      m_since  <= 0;
      m_valid  <= 1'b0;
      m_data   <= 32'h0;
      m_locked <= 1'b1;
    end else begin
      d   = m_delay;
      s   = m_since;
      v   = 1'b0;
      dat = m_data;
      if (bus.delay_load) begin
        d = int'(bus.delay_in);
        s = 0;
      end
      if (bus.in_valid) begin
        hist.push_back(bus.in_data);
        if (s >= d) begin
          v   = 1'b1;
          dat = hist[hist.size() - 1 - d];
        end
        s = s + 1;
      end
      m_delay  <= d;
      m_since  <= s;
      m_valid  <= v;
      m_data   <= dat;
      m_locked <= (d == 0) || (s > d);
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data",  bus.out_data,       m_data);
    chk("locked",    32'(bus.locked),    32'(m_locked));
    chk("cur_delay", 32'(bus.cur_delay), 32'(m_delay));
  end

  task automatic send(input logic v, input logic [15:0] l0, input logic [15:0] l1,
                      input logic ld, input int d);
    bus.in_valid   = v;
    bus.in_data    = {l1, l0};
    bus.delay_load = ld;
    bus.delay_in   = 5'(d);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.delay_load = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'h0;
    bus.delay_load = 1'b0;
    bus.delay_in   = 5'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data,       32'h0);
    chk("rst_locked",    32'(bus.locked),    32'd1);
    chk("rst_cur_delay", 32'(bus.cur_delay), 32'd0);

    // Pass-through at D=0
    for (int k = 1; k <= 10; k++) begin
      send(1'b1, 16'(k), 16'(k), 1'b0, 0);
      if (k == 1) begin
        chk("pt_valid", 32'(bus.out_valid), 32'd1);
        chk("pt_data",  bus.out_data,       32'h0001_0001);
      end
    end

    // Load D=5, then stream 100..139
    send(1'b0, 16'd0, 16'd0, 1'b1, 5);
    chk("d5_locked", 32'(bus.locked),    32'd0);
    chk("d5_delay",  32'(bus.cur_delay), 32'd5);
    for (int k = 0; k < 40; k++) begin
      send(1'b1, 16'(100 + k), 16'(100 + k), 1'b0, 0);
      if (k == 4) chk("d5_pre_valid", 32'(bus.out_valid), 32'd0);
      if (k == 5) begin
        chk("d5_first_valid", 32'(bus.out_valid), 32'd1);
        chk("d5_first_data",  bus.out_data,       {16'd100, 16'd100});
        chk("d5_first_lock",  32'(bus.locked),    32'd1);
      end
    end

    // Reload D=2 together with a sample while running at D=5
    send(1'b1, 16'd200, 16'd200, 1'b1, 2);
    chk("rl_v0", 32'(bus.out_valid), 32'd0);
    send(1'b1, 16'd201, 16'd201, 1'b0, 0);
    chk("rl_v1", 32'(bus.out_valid), 32'd0);
    send(1'b1, 16'd202, 16'd202, 1'b0, 0);
    chk("rl_v2",    32'(bus.out_valid), 32'd1);
    chk("rl_data2", bus.out_data,       {16'd200, 16'd200});

    // D=31, alternating valid/idle, 70 samples (pointer wraps)
    send(1'b0, 16'd0, 16'd0, 1'b1, 31);
    for (int k = 0; k < 70; k++) begin
      send(1'b1, 16'(300 + k), 16'(1300 + k), 1'b0, 0);
      if (k == 30) chk("d31_pre_valid", 32'(bus.out_valid), 32'd0);
      if (k == 31) chk("d31_first_data", bus.out_data, {16'd1300, 16'd300});
      if (k == 69) chk("d31_last_data",  bus.out_data, {16'd1338, 16'd338});
      send(1'b0, 16'hDEAD, 16'hBEEF, 1'b0, 0);
      if (k == 40) chk("d31_idle_valid", 32'(bus.out_valid), 32'd0);
    end

    // Extreme bit patterns per lane, D=3
    send(1'b0, 16'd0, 16'd0, 1'b1, 3);
    send(1'b1, 16'h8000, 16'h7FFF, 1'b0, 0);
    send(1'b1, 16'd1, 16'd2, 1'b0, 0);
    send(1'b1, 16'd3, 16'd4, 1'b0, 0);
    send(1'b1, 16'd5, 16'd6, 1'b0, 0);
    chk("lane_valid", 32'(bus.out_valid), 32'd1);
    chk("lane_data",  bus.out_data,       32'h7FFF_8000);

    // Load D=0 with a sample: immediate pass-through
    send(1'b1, 16'd600, 16'd601, 1'b1, 0);
    chk("d0_valid",  32'(bus.out_valid), 32'd1);
    chk("d0_data",   bus.out_data,       {16'd601, 16'd600});
    chk("d0_locked", 32'(bus.locked),    32'd1);

    // Mid-stream reset at D=5
    send(1'b0, 16'd0, 16'd0, 1'b1, 5);
    for (int k = 0; k < 10; k++) begin
      send(1'b1, 16'(400 + k), 16'(400 + k), 1'b0, 0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = {16'd410, 16'd410};
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_data",  bus.out_data,       32'h0);
    chk("mrst_delay", 32'(bus.cur_delay), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    send(1'b1, 16'd500, 16'd501, 1'b0, 0);
    chk("mrst_pt_valid",  32'(bus.out_valid), 32'd1);
    chk("mrst_pt_data",   bus.out_data,       {16'd501, 16'd500});
    chk("mrst_pt_locked", 32'(bus.locked),    32'd1);
    send(1'b0, 16'd0, 16'd0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_delay_line.md
PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 SHALL provide parameter N, 16, sample width per channel in bits (signed two's complement).
REQ-002 SHALL provide parameter CH, 2, number of parallel channels sharing one delay setting.
REQ-003 SHALL provide parameter MAX_DELAY, 32, buffer depth in samples; power of two, >= 2.
REQ-004 SHALL provide parameter INIT_DELAY, 0, delay in samples applied after reset; 0..MAX_DELAY-1.
REQ-005 SHALL provide clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL provide in_valid  input  1  marks a sample accepted this cycle.
REQ-008 SHALL provide in_data  input  CH*N  channel c occupies bits [c*N +: N].
REQ-009 SHALL provide delay_load  input  1  single-cycle strobe to apply delay_in.
REQ-010 SHALL provide delay_in  input  DW=$clog2(MAX_DELAY)  requested delay in samples.
REQ-011 SHALL provide out_valid  output  1  out_data carries a delayed sample this cycle.
REQ-012 SHALL provide out_data  output  CH*N  delayed samples, same lane packing as in_data.
REQ-013 SHALL provide locked  output  1  high when the fill state machine is in RUN.
REQ-014 SHALL provide cur_delay  output  DW  delay currently in effect.

Function
REQ-015 SHALL measure delay in accepted samples, not clock cycles; cycles with in_valid=0 do not advance the line.
REQ-016 SHALL store samples in a circular buffer of MAX_DELAY x CH*N entries; a DW-bit write pointer advances by 1 per accepted sample and wraps MAX_DELAY-1 -> 0.
REQ-017 SHALL, for accepted sample k with delay D in effect, drive on the following cycle out_data = sample k-D (read address wr_ptr-D modulo MAX_DELAY) and out_valid=1, provided the line is in RUN.
REQ-018 SHALL, when D=0, present the current in_data on out_data one cycle later (registered pass-through).
REQ-019 SHALL keep the fixed latency of REQ-017/REQ-018: exactly one clock from accepted input to out_valid.
REQ-020 SHALL drive out_valid=0 in any cycle not following an accepted sample in RUN; out_data holds its last value when out_valid=0.
REQ-021 SHALL implement a two-state FSM, FILL and RUN; fill_cnt counts samples accepted since the last load or reset and saturates at MAX_DELAY.
REQ-022 SHALL transition FILL -> RUN on the accepted sample for which fill_cnt (pre-increment) equals D; that sample produces the first out_valid.
REQ-023 SHALL, on delay_load, set cur_delay=delay_in, clear fill_cnt, and enter FILL, or RUN directly if delay_in=0; the write pointer and buffer contents are not disturbed.
REQ-024 SHALL, when delay_load and in_valid coincide, apply the new delay first; that sample counts as fill_cnt=0 under the new delay and produces output only if delay_in=0.
REQ-025 SHALL, on delay_load during RUN, suppress out_valid until D_new samples have been accepted, so no sample straddling two delay settings is emitted.
REQ-026 SHALL treat all CH lanes identically and in lockstep; no arithmetic is applied to data, and bit patterns pass unchanged.
REQ-027 SHALL drive locked = (state==RUN), registered, and update it in the same cycle as the state change.

Reset
REQ-028 SHALL, on rst assertion, immediately clear wr_ptr, fill_cnt, out_valid and out_data, set cur_delay=INIT_DELAY, and enter FILL, or RUN if INIT_DELAY=0.
REQ-029 SHALL leave buffer memory uninitialised; the FILL gating guarantees stale contents are never output.
REQ-030 SHALL, on rst asserted mid-stream, discard any in-flight output; after release, behaviour matches power-on exactly.

Verification (N=16, CH=2, MAX_DELAY=32, INIT_DELAY=0)
REQ-031 SHALL pass: after reset, continuous in_valid with samples 1,2,3,... in both lanes -> out_data equals the input one cycle later, out_valid=1 from the first cycle, and locked=1.
REQ-032 SHALL pass: load D=5, then feed 100..139 -> out_valid first high one cycle after sample 105 with value 100; locked rises on the same edge; output then tracks input-5.
REQ-033 SHALL pass: D=31 with in_valid toggling 1/0 and 70 samples fed (pointer wraps twice) -> each output equals the input 31 samples earlier, with no output on idle cycles.
REQ-034 SHALL pass: in RUN at D=5, pulse delay_load with D=2 together with in_valid -> out_valid=0 for that sample and the next; the third sample after the load outputs the load-cycle sample.
REQ-035 SHALL pass: lane 0 = 0x8000, lane 1 = 0x7FFF, D=3 -> both values emerge bit-exact in their own lanes after 3 samples.
REQ-036 SHALL pass: assert rst for one cycle mid-stream at D=5 -> out_valid=0 and out_data=0 immediately, cur_delay=0, and pass-through resumes on the first accepted sample after release.
